// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - memory request/response types and the arbiter bus interface
package mem_port_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] address;
    logic [31:0] data;
    logic [3:0]  strobe;
    logic        wen;
  } Memory_Request;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } Memory_Response;

endpackage

interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
);
  localparam int GRANT_W = $clog2(NUM_REQ);

  Memory_Request  [NUM_REQ-1:0] req_i;
  Memory_Response [NUM_REQ-1:0] resp_o;
  Memory_Request                mem_req_o;
  Memory_Response               mem_resp_i;
  logic [GRANT_W-1:0]           grant_o;
  logic                         busy_o;
  logic                         err_o;

  modport slave (
    input  req_i, mem_resp_i,
    output resp_o, mem_req_o, grant_o, busy_o, err_o
  );

  modport master (
    output req_i, mem_resp_i,
    input  resp_o, mem_req_o, grant_o, busy_o, err_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin single-outstanding memory port arbiter
// Optional BUSY timeout abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                  clk,
  input logic                  reset,
  mem_port_arbiter_if.slave    bus
);
  localparam int GRANT_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                       state_q, state_d;
  Memory_Request                mem_req_q, mem_req_d;
  Memory_Response [NUM_REQ-1:0] resp_q, resp_d;
  logic [GRANT_W-1:0]           grant_q, grant_d;
  logic [GRANT_W-1:0]           last_q, last_d;
  logic                         err_q, err_d;
  logic                         found;
  logic [GRANT_W-1:0]           pick;
  logic [GRANT_W-1:0]           idx;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = GRANT_W'((int'(last_q) + i) % NUM_REQ);
      if (!found && bus.req_i[idx].valid) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_req_d = mem_req_q;
    resp_d    = '0;
    grant_d   = grant_q;
    last_d    = last_q;
    err_d     = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          mem_req_d       = bus.req_i[pick];
          mem_req_d.valid = 1'b1;
          grant_d         = pick;
          last_d          = pick;
          state_d         = BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d           = '0;
`endif
        end
      end
      BUSY: begin
        if (bus.mem_resp_i.valid) begin
          resp_d[grant_q].valid = 1'b1;
          resp_d[grant_q].data  = bus.mem_resp_i.data;
          mem_req_d.valid       = 1'b0;
          state_d               = RESP;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        // A response in the final counted cycle still wins over the abort.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          resp_d[grant_q].valid = 1'b1;
          err_d                 = 1'b1;
          mem_req_d.valid       = 1'b0;
          state_d               = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req_q <= '0;
      resp_q    <= '0;
      grant_q   <= '0;
      last_q    <= GRANT_W'(NUM_REQ - 1);
      err_q     <= 1'b0;
    end else begin
      mem_req_q <= mem_req_d;
      resp_q    <= resp_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      err_q     <= err_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign bus.mem_req_o = mem_req_q;
  assign bus.resp_o    = resp_q;
  assign bus.grant_o   = grant_q;
  assign bus.busy_o    = (state_q != IDLE);
  assign bus.err_o     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter (honours MEM_ARB_TIMEOUT_EN)
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int TO      = 8;

  typedef logic [0:0] ridx_t;
  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        err;
  } sb_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  mem_port_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_total = 0;
  int          n_pass  = 0;
  sb_t         sb[$];
  logic [31:0] grant_log[$];
  int          addr_owner[logic [31:0]];
  bit          mem_en = 1'b1;
  int          mem_lat = 4;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_data = '0;
  bit          pulse_req = 1'b0;
  int          seen = 0;
  logic        prev_valid = 1'b0;
  int          resp_seen = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Memory model: answers mem_lat cycles after first seeing valid; expectation queued as it answers.
  always @(negedge clk) begin
    if (reset) begin
      seen = 0;
      bus.mem_resp_i = '0;
    end else begin
      bus.mem_resp_i = '0;
      if (pulse_req) begin
        bus.mem_resp_i.valid = 1'b1;
        bus.mem_resp_i.data  = 32'hBAD0BAD0;
        pulse_req = 1'b0;
      end else if (mem_en && bus.mem_req_o.valid) begin
        seen++;
        if (seen == mem_lat + 1) begin
          bus.mem_resp_i.valid = 1'b1;
          bus.mem_resp_i.data  = ovr_en ? ovr_data : (bus.mem_req_o.address ^ 32'hC0DE0000);
          sb.push_back('{addr_owner[bus.mem_req_o.address], bus.mem_resp_i.data, 1'b0});
        end
      end else begin
        seen = 0;
      end
    end
  end

  // Response monitor and scoreboard comparison.
  always @(negedge clk) begin
    int  nv;
    sb_t e;
    if (!reset) begin
      nv = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (bus.resp_o[ridx_t'(k)].valid) begin
          nv++;
          resp_seen++;
          if (sb.size() == 0) begin
            check("resp_unexpected", 1, 0);
          end else begin
            e = sb.pop_front();
            check("resp_idx", k, e.idx);
            check("resp_data", bus.resp_o[ridx_t'(k)].data, e.data);
            check("resp_err", bus.err_o, e.err);
          end
        end else begin
          check("resp_zero_data", bus.resp_o[ridx_t'(k)].data, 0);
        end
      end
      if (nv > 0) check("resp_onehot", nv, 1);
      else check("err_idle", bus.err_o, 0);
      if (bus.mem_req_o.valid && !prev_valid) begin
        grant_log.push_back(bus.mem_req_o.address);
        if (addr_owner.exists(bus.mem_req_o.address))
          check("grant_idx", bus.grant_o, addr_owner[bus.mem_req_o.address]);
      end
      prev_valid = bus.mem_req_o.valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic drive_req(input int k, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic w);
    bus.req_i[ridx_t'(k)] = '{valid: 1'b1, address: a, data: d, strobe: s, wen: w};
    addr_owner[a] = k;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.req_i = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_resp(input int k, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.resp_o[ridx_t'(k)].valid && n < budget);
    check("wait_resp", bus.resp_o[ridx_t'(k)].valid, 1);
    bus.req_i[ridx_t'(k)].valid = 1'b0;
  endtask

  task automatic wait_mem_valid(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mem_req_o.valid && n < budget);
    check("wait_mem_valid", bus.mem_req_o.valid, 1);
  endtask

  initial begin
    int          sent[NUM_REQ];
    int          n;
    logic [31:0] exp_log[4];

    bus.req_i = '0;
    @(negedge clk);
    check("rst_busy", bus.busy_o, 0);
    check("rst_mem_req", bus.mem_req_o, 0);
    check("rst_resp", bus.resp_o, 0);
    check("rst_grant", bus.grant_o, 0);
    check("rst_err", bus.err_o, 0);
    reset = 1'b0;

    // Single read with exact cycle timing.
    @(negedge clk);
    ovr_en = 1'b1; ovr_data = 32'hDEADBEEF; mem_lat = 4;
    drive_req(0, 32'h10, 32'h0, 4'h0, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check($sformatf("t1_memv_c%0d", c), bus.mem_req_o.valid, (c <= 5));
      if (c <= 5) check("t1_addr", bus.mem_req_o.address, 32'h10);
      check($sformatf("t1_resp0_c%0d", c), bus.resp_o[0].valid, (c == 6));
      check("t1_resp1", bus.resp_o[1].valid, 0);
      if (c == 6) bus.req_i[0].valid = 1'b0;
    end
    ovr_en = 1'b0;

    // Contention right after reset: grants alternate starting at 0.
    do_reset();
    grant_log.delete();
    mem_lat = 2;
    sent = '{0, 0};
    drive_req(0, 32'h1000, 32'h0, 4'h0, 1'b0);
    drive_req(1, 32'h2000, 32'h0, 4'h0, 1'b0);
    n = 0;
    while ((bus.req_i[0].valid || bus.req_i[1].valid || bus.busy_o) && n < 200) begin
      @(negedge clk);
      n++;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (bus.resp_o[ridx_t'(k)].valid) begin
          sent[k]++;
          if (sent[k] < 2) drive_req(k, 32'h1000 * (k + 1) + 4 * sent[k], 32'h0, 4'h0, 1'b0);
          else bus.req_i[ridx_t'(k)].valid = 1'b0;
        end
      end
    end
    check("t2_done", n < 200, 1);
    exp_log = '{32'h1000, 32'h2000, 32'h1004, 32'h2004};
    check("t2_n_grants", grant_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < grant_log.size()) check($sformatf("t2_grant%0d", i), grant_log[i], exp_log[i]);

    // Write passthrough from requester 1.
    @(negedge clk);
    drive_req(1, 32'h200, 32'h12345678, 4'b0011, 1'b1);
    wait_mem_valid(20);
    check("t3_addr", bus.mem_req_o.address, 32'h200);
    check("t3_data", bus.mem_req_o.data, 32'h12345678);
    check("t3_strobe", bus.mem_req_o.strobe, 4'b0011);
    check("t3_wen", bus.mem_req_o.wen, 1);
    n = resp_seen;
    wait_resp(1, 50);
    repeat (3) @(negedge clk);
    check("t3_one_pulse", resp_seen - n, 1);

    // Request latched while BUSY.
    mem_lat = 6;
    drive_req(0, 32'h10, 32'h0, 4'h0, 1'b0);
    wait_mem_valid(20);
    bus.req_i[0].address = 32'h44;
    while (bus.mem_req_o.valid) begin
      check("t4_latched_addr", bus.mem_req_o.address, 32'h10);
      @(negedge clk);
    end
    wait_resp(0, 50);

    // Asynchronous reset in the middle of BUSY.
    repeat (2) @(negedge clk);
    mem_en = 1'b0;
    drive_req(0, 32'h10, 32'h0, 4'h0, 1'b0);
    repeat (3) @(negedge clk);
    check("t5_busy_before", bus.busy_o, 1);
    #2 reset = 1'b1;
    #1;
    check("t5_busy_async", bus.busy_o, 0);
    check("t5_memv_async", bus.mem_req_o.valid, 0);
    bus.req_i = '0;
    @(negedge clk);
    reset = 1'b0;
    check("t5_grant_rst", bus.grant_o, 0);
    n = resp_seen;
    pulse_req = 1'b1;
    repeat (6) @(negedge clk);
    check("t5_no_resp", resp_seen - n, 0);

    // No response from memory.
    @(negedge clk);
    drive_req(0, 32'h10, 32'h0, 4'h0, 1'b0);
`ifdef MEM_ARB_TIMEOUT_EN
    sb.push_back('{0, 32'h0, 1'b1});
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check($sformatf("t6_resp_c%0d", c), bus.resp_o[0].valid, (c == TO + 1));
      check($sformatf("t6_err_c%0d", c), bus.err_o, (c == TO + 1));
      if (c == TO + 1) bus.req_i[0].valid = 1'b0;
    end
    check("t6_idle", bus.busy_o, 0);
`else
    n = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus.busy_o) n++;
    end
    check("t6_busy_forever", n, 100);
    do_reset();
`endif
    mem_en = 1'b1;
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
